// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative unsigned 32-bit multiply/divide unit with a register-file style
//   write-back port. One operation at a time: a start pulse in IDLE captures
//   the operands, 32 shift-add (multiply) or restoring-division steps follow,
//   and the result is presented with a one-cycle write strobe.
//
// Parameters
//   EARLY_ZERO  1: divide/remainder by zero completes without iterating
//               0: divide by zero runs the full 32 iterations
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_start      request, sampled only while idle
//   i_op         00 MULLO, 01 MULHI, 10 DIVQ, 11 DIVR
//   i_operand_a  first operand (register-file read port A)
//   i_operand_b  second operand (register-file read port B)
//   i_dest       destination register address
//   o_busy       operation in progress, start ignored while high
//   o_wb_en      one-cycle write strobe
//   o_wb_addr    write address, held between strobes
//   o_wb_data    write data, held between strobes
// -----------------------------------------------------------------------------
module muldiv_unit #(
   parameter bit EARLY_ZERO = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   input  logic [1:0]  i_op,
   input  logic [31:0] i_operand_a,
   input  logic [31:0] i_operand_b,
   input  logic [4:0]  i_dest,
   output logic        o_busy,
   output logic        o_wb_en,
   output logic [4:0]  o_wb_addr,
   output logic [31:0] o_wb_data
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      r_state;
   logic [1:0]  r_op;
   logic [4:0]  r_dest;
   logic [4:0]  r_count;
   // r_opnd: multiplicand for multiply, divisor for divide.
   // r_hi/r_lo: product halves for multiply; remainder/quotient for divide
   // (r_lo starts as the dividend and is shifted out as quotient bits enter).
   logic [31:0] r_opnd;
   logic [31:0] r_hi;
   logic [31:0] r_lo;

   logic [32:0] w_mul_sum;
   logic [31:0] w_mul_hi;
   logic [31:0] w_mul_lo;
   logic [32:0] w_div_shift;
   logic [32:0] w_div_diff;
   logic        w_div_ge;
   logic [31:0] w_div_hi;
   logic [31:0] w_div_lo;
   logic [31:0] w_next_hi;
   logic [31:0] w_next_lo;
   logic [31:0] w_result;
   logic        w_div_zero;

   // One multiply step: conditionally add the multiplicand into the upper
   // half, then shift the 65-bit {carry, hi, lo} right by one.
   always_comb begin
      w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : 33'd0);
      w_mul_hi  = w_mul_sum[32:1];
      w_mul_lo  = {w_mul_sum[0], r_lo[31:1]};
   end

   // One restoring-division step: shift the next dividend bit into the
   // partial remainder and keep the difference only if it did not borrow.
   // The remainder stays below the divisor (or is a prefix of the dividend
   // when dividing by zero), so the kept value always fits in 32 bits.
   always_comb begin
      w_div_shift = {r_hi, r_lo[31]};
      w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
      w_div_diff  = w_div_shift - {1'b0, r_opnd};
      w_div_hi    = w_div_ge ? w_div_diff[31:0] : w_div_shift[31:0];
      w_div_lo    = {r_lo[30:0], w_div_ge};
   end

   always_comb begin
      w_next_hi = r_op[1] ? w_div_hi : w_mul_hi;
      w_next_lo = r_op[1] ? w_div_lo : w_mul_lo;
      // MULHI and DIVR read the upper register, MULLO and DIVQ the lower.
      w_result  = r_op[0] ? w_next_hi : w_next_lo;
      w_div_zero = i_op[1] && (i_operand_b == 32'd0);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= S_IDLE;
         r_op      <= 2'd0;
         r_dest    <= 5'd0;
         r_count   <= 5'd0;
         r_opnd    <= 32'd0;
         r_hi      <= 32'd0;
         r_lo      <= 32'd0;
         o_busy    <= 1'b0;
         o_wb_en   <= 1'b0;
         o_wb_addr <= 5'd0;
         o_wb_data <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               o_wb_en <= 1'b0;
               if (i_start) begin
                  r_op    <= i_op;
                  r_dest  <= i_dest;
                  r_count <= 5'd0;
                  r_hi    <= 32'd0;
                  o_busy  <= 1'b1;
                  if (i_op[1]) begin
                     r_opnd <= i_operand_b;
                     r_lo   <= i_operand_a;
                  end else begin
                     r_opnd <= i_operand_a;
                     r_lo   <= i_operand_b;
                  end
                  if (EARLY_ZERO && w_div_zero) begin
                     // Result is known up front: all-ones quotient,
                     // remainder equal to the dividend.
                     r_state   <= S_DONE;
                     o_wb_en   <= 1'b1;
                     o_wb_addr <= i_dest;
                     o_wb_data <= i_op[0] ? i_operand_a : 32'hFFFF_FFFF;
                  end else begin
                     r_state <= S_RUN;
                  end
               end
            end

            S_RUN: begin
               r_hi    <= w_next_hi;
               r_lo    <= w_next_lo;
               r_count <= r_count + 5'd1;
               // The last step's result goes straight to the write port so
               // the strobe lands in the DONE cycle.
               if (r_count == 5'd31) begin
                  r_state   <= S_DONE;
                  o_wb_en   <= 1'b1;
                  o_wb_addr <= r_dest;
                  o_wb_data <= w_result;
               end
            end

            S_DONE: begin
               r_state <= S_IDLE;
               o_busy  <= 1'b0;
               o_wb_en <= 1'b0;
               r_count <= 5'd0;
            end

            default: begin
               r_state <= S_IDLE;
               o_busy  <= 1'b0;
               o_wb_en <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed, table-driven bench for muldiv_unit. Two instances share the
//   same stimulus: dut 0 with EARLY_ZERO = 1, dut 1 with EARLY_ZERO = 0.
//   Cycle k is the clock period after rising edge k-1 of the transaction,
//   edge 0 being the one that samples start; outputs are sampled at the
//   falling edge inside each period.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] opa;
   logic [31:0] opb;
   logic [4:0]  dest;
   logic [1:0]  busy;
   logic [1:0]  wb_en;
   logic [4:0]  wb_addr [2];
   logic [31:0] wb_data [2];

   int n_checks;
   int n_errors;

   muldiv_unit #(.EARLY_ZERO(1'b1)) u_dut_ez (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_start     (start),
      .i_op        (op),
      .i_operand_a (opa),
      .i_operand_b (opb),
      .i_dest      (dest),
      .o_busy      (busy[0]),
      .o_wb_en     (wb_en[0]),
      .o_wb_addr   (wb_addr[0]),
      .o_wb_data   (wb_data[0])
   );

   muldiv_unit #(.EARLY_ZERO(1'b0)) u_dut_full (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_start     (start),
      .i_op        (op),
      .i_operand_a (opa),
      .i_operand_b (opb),
      .i_dest      (dest),
      .o_busy      (busy[1]),
      .o_wb_en     (wb_en[1]),
      .o_wb_addr   (wb_addr[1]),
      .o_wb_data   (wb_data[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  dest;
      logic [31:0] exp;
      int          sp1;      // extra start pulse cycle, -1 = none
      int          sp2;
      bit          scramble; // change inputs after cycle 0
   } vec_t;

   localparam int NVEC = 12;
   vec_t vecs [NVEC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Run one transaction on both instances and check strobe timing,
   // strobe count, address, data and busy around completion.
   task automatic run_vec(input vec_t v, input string tag);
      int          pulses [2];
      int          cyc    [2];
      logic [4:0]  addr   [2];
      logic [31:0] data   [2];
      int          exp_cyc [2];
      exp_cyc[0] = (v.op[1] && v.b == 32'd0) ? 1 : 33;
      exp_cyc[1] = 33;
      for (int d = 0; d < 2; d++) begin
         pulses[d] = 0; cyc[d] = -1; addr[d] = 5'd0; data[d] = 32'd0;
      end
      start = 1'b1; op = v.op; opa = v.a; opb = v.b; dest = v.dest;
      @(posedge clk);
      for (int k = 1; k <= 36; k++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (wb_en[d]) begin
               pulses[d]++;
               cyc[d]  = k;
               addr[d] = wb_addr[d];
               data[d] = wb_data[d];
            end
            if (k == exp_cyc[d])
               check($sformatf("%s dut%0d busy@%0d", tag, d, k), {31'd0, busy[d]}, 32'd1);
            if (k == exp_cyc[d] + 1)
               check($sformatf("%s dut%0d idle@%0d", tag, d, k), {31'd0, busy[d]}, 32'd0);
         end
         start = (k == v.sp1) || (k == v.sp2);
         if (v.scramble) begin
            op   = 2'($urandom);
            opa  = $urandom;
            opb  = $urandom;
            dest = 5'($urandom);
         end
      end
      start = 1'b0;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("%s dut%0d pulses", tag, d), pulses[d], 32'd1);
         check($sformatf("%s dut%0d wb_cycle", tag, d), cyc[d], exp_cyc[d]);
         check($sformatf("%s dut%0d wb_addr", tag, d), {27'd0, addr[d]}, {27'd0, v.dest});
         check($sformatf("%s dut%0d wb_data", tag, d), data[d], v.exp);
         $display("%s dut%0d op=%0d a=%0h b=%0h dest=%0d -> data=%0h cycle=%0d", tag, d,
                  v.op, v.a, v.b, v.dest, data[d], cyc[d]);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t rv;
      n_checks = 0;
      n_errors = 0;
      start = 1'b0; op = 2'd0; opa = 32'd0; opb = 32'd0; dest = 5'd0;

      vecs[0]  = '{2'b00, 32'd7,          32'd6,          5'd3,  32'd42,         -1, -1, 1'b0};
      vecs[1]  = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd5,  32'hFFFF_FFFE, -1, -1, 1'b0};
      vecs[2]  = '{2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd6,  32'h0000_0001, -1, -1, 1'b0};
      vecs[3]  = '{2'b10, 32'd100,        32'd7,          5'd7,  32'd14,         -1, -1, 1'b0};
      vecs[4]  = '{2'b11, 32'd100,        32'd7,          5'd8,  32'd2,          -1, -1, 1'b0};
      vecs[5]  = '{2'b10, 32'd5,          32'd0,          5'd10, 32'hFFFF_FFFF, -1, -1, 1'b0};
      vecs[6]  = '{2'b11, 32'd5,          32'd0,          5'd11, 32'd5,          -1, -1, 1'b0};
      vecs[7]  = '{2'b00, 32'd3,          32'd4,          5'd0,  32'd12,          5, 33, 1'b1};
      vecs[8]  = '{2'b01, 32'h8000_0000,  32'd4,          5'd31, 32'd2,          -1, -1, 1'b0};
      vecs[9]  = '{2'b10, 32'hFFFF_FFFF,  32'd1,          5'd12, 32'hFFFF_FFFF, -1, -1, 1'b0};
      vecs[10] = '{2'b11, 32'hDEAD_BEEF,  32'h0001_0000,  5'd13, 32'h0000_BEEF, -1, -1, 1'b0};
      vecs[11] = '{2'b10, 32'd3,          32'd10,         5'd14, 32'd0,          -1, -1, 1'b0};

      // Reset values must appear without any clock edge.
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("reset dut%0d busy", d), {31'd0, busy[d]}, 32'd0);
         check($sformatf("reset dut%0d wb_en", d), {31'd0, wb_en[d]}, 32'd0);
         check($sformatf("reset dut%0d wb_addr", d), {27'd0, wb_addr[d]}, 32'd0);
         check($sformatf("reset dut%0d wb_data", d), wb_data[d], 32'd0);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // First start right after reset release.
      for (int i = 0; i < NVEC; i++)
         run_vec(vecs[i], $sformatf("vec%0d", i));

      // Held outputs while idle: last vector wrote dest 14, data 0.
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("hold dut%0d wb_addr", d), {27'd0, wb_addr[d]}, 32'd14);
         check($sformatf("hold dut%0d wb_en", d), {31'd0, wb_en[d]}, 32'd0);
      end

      // Reset in cycle 10 of a divide aborts it with no later strobe.
      start = 1'b1; op = 2'b10; opa = 32'd100; opb = 32'd7; dest = 5'd20;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int k = 2; k <= 10; k++) @(negedge clk);
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         check($sformatf("abort dut%0d busy", d), {31'd0, busy[d]}, 32'd0);
         check($sformatf("abort dut%0d wb_en", d), {31'd0, wb_en[d]}, 32'd0);
      end
      $display("abort: reset asserted in cycle 10 of DIVQ 100/7");
      @(negedge clk);
      rst_n = 1'b1;
      // New MULLO right away; run_vec also counts strobes, so any leftover
      // strobe from the aborted divide shows up as an extra pulse.
      rv = '{2'b00, 32'd2, 32'd2, 5'd9, 32'd4, -1, -1, 1'b0};
      run_vec(rv, "post_reset");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter EARLY_ZERO, default 1; 1 = divide/remainder by zero skips iteration, 0 = runs full 32 iterations.
REQ-002 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request; sampled on a rising edge only while idle.
REQ-005 SHALL have port op  input  2  operation: 00 MULLO, 01 MULHI, 10 DIVQ, 11 DIVR (all unsigned).
REQ-006 SHALL have port operand_a  input  32  first operand, driven from register-file read port A.
REQ-007 SHALL have port operand_b  input  32  second operand, driven from register-file read port B.
REQ-008 SHALL have port dest  input  5  destination register address.
REQ-009 SHALL have port busy  output  1  operation in progress; start ignored while high.
REQ-010 SHALL have port wb_en  output  1  one-cycle write strobe to the register-file write port.
REQ-011 SHALL have port wb_addr  output  5  write address, valid when wb_en is high.
REQ-012 SHALL have port wb_data  output  32  write data, valid when wb_en is high.

Function
REQ-013 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; IDLE -> DONE directly only for early-zero divide.
REQ-014 SHALL, in IDLE with start high at an edge, capture op, operand_a, operand_b and dest; later input changes SHALL have no effect.
REQ-015 SHALL number the start-sampled cycle 0; busy high cycles 1..33, iterations in cycles 1..32, DONE in cycle 33, wb_en high in cycle 33 only, busy low from cycle 34.
REQ-016 SHALL accept a new start in cycle 34 at the earliest; start high while busy (including DONE) SHALL be ignored, neither queued nor corrupting state.
REQ-017 SHALL compute multiply as 32-step shift-add into a 64-bit product; MULLO returns bits [31:0], MULHI bits [63:32].
REQ-018 SHALL compute divide as 32-step restoring division; DIVQ returns quotient, DIVR remainder.
REQ-019 SHALL, for divide with operand_b = 0, return DIVQ = 32'hFFFFFFFF and DIVR = operand_a.
REQ-020 SHALL, when EARLY_ZERO = 1 and a divide has operand_b = 0, go IDLE -> DONE: busy and wb_en high in cycle 1 only.
REQ-021 SHALL write dest = 0 like any other address; no address is special.
REQ-022 SHALL drive all outputs from registers; no combinational path from inputs to outputs.
REQ-023 SHALL hold wb_addr and wb_data at last written values while wb_en is low.

Reset
REQ-024 SHALL, while reset is low, force state IDLE, busy 0, wb_en 0, wb_addr 0, wb_data 0, iteration counter 0, with no clock required.
REQ-025 SHALL abort any operation when reset asserts mid-operation; no wb_en pulse for the aborted operation after release.
REQ-026 SHALL accept start on the first rising edge after reset deasserts.

Verification
REQ-027 SHALL cover: MULLO 7 x 6, dest 3 -> wb_en cycle 33 only, wb_addr 3, wb_data 42; busy low cycle 34.
REQ-028 SHALL cover: MULHI 32'hFFFFFFFF x 32'hFFFFFFFF -> wb_data 32'hFFFFFFFE; MULLO same operands -> 32'h00000001.
REQ-029 SHALL cover: DIVQ 100 / 7 -> 14; DIVR 100 / 7 -> 2; both at cycle 33.
REQ-030 SHALL cover: DIVQ 5 / 0 with EARLY_ZERO = 1 -> wb_data 32'hFFFFFFFF in cycle 1; DIVR 5 / 0 with EARLY_ZERO = 0 -> wb_data 5 in cycle 33.
REQ-031 SHALL cover: start pulses in cycles 5 and 33 of an active MULLO 3 x 4 -> single wb_en pulse, wb_data 12; operand changes after cycle 0 have no effect.
REQ-032 SHALL cover: reset low in cycle 10 of a DIVQ -> busy and wb_en 0 immediately; no wb_en after release; new MULLO 2 x 2 started next cycle -> 4.
